// File: rtl/spi_mem_ctrl.sv
// SPI RAM initiator: one 16-bit word per request, mode 0, SPI clock = clk/2.
// Optional fast-read (0x0B + 8 dummy bits) enabled by defining SPI_MEM_CTRL_FAST_READ_EN.
module spi_mem_ctrl #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic              spi_select,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned CMD_W = 8;
  localparam int unsigned NBITS = CMD_W + ADDR_W + DATA_W;
`ifdef SPI_MEM_CTRL_FAST_READ_EN
  localparam int unsigned DUMMY_W  = 8;
  localparam logic [7:0]  CMD_READ = 8'h0B;
`else
  localparam int unsigned DUMMY_W  = 0;
  localparam logic [7:0]  CMD_READ = 8'h03;
`endif
  localparam logic [7:0]  CMD_WRITE  = 8'h02;
  localparam int unsigned NBITS_RD   = NBITS + DUMMY_W;
  localparam int unsigned SR_W       = NBITS_RD;
  localparam int unsigned CNT_W      = $clog2(SR_W);
  localparam int unsigned DATA_START = CMD_W + ADDR_W + DUMMY_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [SR_W-1:0]   r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_phase;
  logic              r_write;
  logic [DATA_W-1:0] r_cap;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_valid;
  logic              r_req_ready;
  logic              r_busy;
  logic              r_spi_select;
  logic              r_spi_clk;
  logic              r_spi_mosi;

  logic [1:0]        w_state_nxt;
  logic [SR_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic              w_phase_nxt;
  logic              w_write_nxt;
  logic [DATA_W-1:0] w_cap_nxt;
  logic [DATA_W-1:0] w_resp_rdata_nxt;
  logic              w_resp_valid_nxt;
  logic              w_spi_select_nxt;
  logic              w_spi_clk_nxt;
  logic              w_spi_mosi_nxt;
  logic [NBITS-1:0]  w_frame;
  logic [SR_W-1:0]   w_load;
  logic [CNT_W-1:0]  w_last;
  logic [DATA_W-1:0] w_cap_shift;

  // Frame is left-aligned so the shift register MSB is always the next bit on the wire.
  always_comb begin
    w_frame     = {(req_write ? CMD_WRITE : CMD_READ), req_addr,
                   (req_write ? req_wdata : DATA_W'(0))};
    w_load      = SR_W'(w_frame) << (SR_W - NBITS);
    w_last      = r_write ? CNT_W'(NBITS - 1) : CNT_W'(NBITS_RD - 1);
    w_cap_shift = {r_cap[DATA_W-2:0], spi_miso};
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_phase_nxt      = r_phase;
    w_write_nxt      = r_write;
    w_cap_nxt        = r_cap;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_valid_nxt = 1'b0;
    w_spi_select_nxt = 1'b0;
    w_spi_clk_nxt    = 1'b0;
    w_spi_mosi_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt      = S_SHIFT;
          w_shift_nxt      = w_load;
          w_bit_cnt_nxt    = '0;
          w_phase_nxt      = 1'b0;
          w_write_nxt      = req_write;
          w_spi_select_nxt = 1'b1;
          w_spi_mosi_nxt   = w_load[SR_W-1];
        end
      end
      S_SHIFT: begin
        w_spi_select_nxt = 1'b1;
        if (!r_phase) begin
          w_phase_nxt    = 1'b1;
          w_spi_clk_nxt  = 1'b1;
          w_spi_mosi_nxt = r_spi_mosi;
        end else begin
          w_phase_nxt   = 1'b0;
          w_shift_nxt   = r_shift << 1;
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          if (!r_write && (r_bit_cnt >= CNT_W'(DATA_START))) begin
            w_cap_nxt = w_cap_shift;
          end
          if (r_bit_cnt == w_last) begin
            w_state_nxt      = S_DONE;
            w_spi_select_nxt = 1'b0;
            w_resp_valid_nxt = 1'b1;
            if (!r_write) begin
              w_resp_rdata_nxt = w_cap_shift;
            end
          end else begin
            w_spi_mosi_nxt = r_shift[SR_W-2];
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_phase      <= 1'b0;
      r_write      <= 1'b0;
      r_cap        <= '0;
      r_resp_rdata <= '0;
      r_resp_valid <= 1'b0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_spi_select <= 1'b0;
      r_spi_clk    <= 1'b0;
      r_spi_mosi   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_phase      <= w_phase_nxt;
      r_write      <= w_write_nxt;
      r_cap        <= w_cap_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_spi_select <= w_spi_select_nxt;
      r_spi_clk    <= w_spi_clk_nxt;
      r_spi_mosi   <= w_spi_mosi_nxt;
    end
  end

  assign req_ready  = r_req_ready;
  assign busy       = r_busy;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign spi_select = r_spi_select;
  assign spi_clk    = r_spi_clk;
  assign spi_mosi   = r_spi_mosi;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: SPI RAM responder plus a word-level memory reference model.
module tb_spi_mem_ctrl;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
`ifdef SPI_MEM_CTRL_FAST_READ_EN
  localparam int unsigned DUMMY  = 8;
  localparam logic [7:0]  RD_CMD = 8'h0B;
`else
  localparam int unsigned DUMMY  = 0;
  localparam logic [7:0]  RD_CMD = 8'h03;
`endif
  localparam int unsigned WR_BITS = 8 + ADDR_W + DATA_W;
  localparam int unsigned RD_BITS = WR_BITS + DUMMY;
  localparam int unsigned RD_TAIL = DATA_W + DUMMY;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              busy;
  logic              spi_select;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  spi_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy),
    .spi_select (spi_select),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always #5 clk = ~clk;

  // SPI RAM responder: decodes MOSI on spi_clk rise, drives MISO after spi_clk falls.
  logic [15:0] ram [logic [23:0]];
  logic [63:0] rx_bits = '0;
  int          rx_n = 0;
  logic [7:0]  rx_cmd = '0;
  logic [23:0] rx_addr = '0;
  logic [15:0] tx_word = '0;
  int          sel_rise_cnt = 0;

  function automatic logic [15:0] ram_rd(input logic [23:0] a);
    return ram.exists(a) ? ram[a] : 16'h0000;
  endfunction

  always @(posedge spi_select or posedge spi_clk) begin
    if (!spi_clk) begin
      rx_n    = 0;
      rx_bits = '0;
      rx_cmd  = '0;
      rx_addr = '0;
      sel_rise_cnt++;
    end else if (spi_select) begin
      rx_bits = {rx_bits[62:0], spi_mosi};
      rx_n++;
      if (rx_n == 32) begin
        rx_cmd  = rx_bits[31:24];
        rx_addr = rx_bits[23:0];
        tx_word = ram_rd(rx_bits[23:0]);
      end
      if (rx_n == 48 && rx_cmd == 8'h02) ram[rx_addr] = rx_bits[15:0];
    end
  end

  always @(negedge spi_clk) begin
    int ds;
    ds = (rx_cmd == 8'h0B) ? 40 : 32;
    if (spi_select && rx_n >= ds && rx_n < ds + 16) spi_miso = tx_word[4'(15 - (rx_n - ds))];
    else spi_miso = 1'b0;
  end

  int resp_cnt = 0;
  always @(posedge clk) if (resp_valid) resp_cnt++;

  // Reference model: word-addressed memory and the last read word.
  logic [15:0] ref_mem [logic [23:0]];
  logic [15:0] exp_rdata = '0;

  function automatic logic [15:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic start_req(input logic wr, input logic [23:0] a, input logic [15:0] wd);
    @(negedge clk);
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 24'($urandom);
    req_wdata = 16'($urandom);
    check_eq("select_after_accept", 32'(spi_select), 32'd1);
  endtask

  task automatic wait_resp(output int lat);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_txn(input logic wr, input logic [23:0] a, input logic [15:0] wd);
    int lat;
    start_req(wr, a, wd);
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    wait_resp(lat);
    if (wr) ref_mem[a] = wd;
    else exp_rdata = ref_rd(a);
    check_eq("resp_latency", 32'(lat), wr ? 32'(2 * WR_BITS) : 32'(2 * RD_BITS));
    check_eq("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
    check_eq("ready_in_done", 32'(req_ready), 32'd0);
    check_eq("frame_bits", 32'(rx_n), wr ? 32'(WR_BITS) : 32'(RD_BITS));
    check_eq("mosi_cmd", 32'(rx_cmd), wr ? 32'h02 : 32'(RD_CMD));
    check_eq("mosi_addr", 32'(rx_addr), 32'(a));
    if (wr) check_eq("ram_word", 32'(ram_rd(a)), 32'(ref_rd(a)));
    else check_eq("mosi_rd_tail", 32'(rx_bits[RD_TAIL-1:0]), 32'd0);
    @(posedge clk);
    #1;
    check_eq("resp_one_cycle", 32'(resp_valid), 32'd0);
    check_eq("ready_after", 32'(req_ready), 32'd1);
    check_eq("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int low;
    int rc0;
    int sc0;
    logic [15:0] wd;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check_eq("rst_spi_select", 32'(spi_select), 32'd0);
    check_eq("rst_spi_clk", 32'(spi_clk), 32'd0);
    check_eq("rst_spi_mosi", 32'(spi_mosi), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Preload, read back, write then read.
    run_txn(1'b1, 24'h000010, 16'hBEEF);
    run_txn(1'b0, 24'h000010, 16'h0000);
    run_txn(1'b1, 24'h000020, 16'h1234);
    run_txn(1'b0, 24'h000020, 16'h0000);

    // Back-to-back reads with req_valid held high.
    run_txn(1'b1, 24'h000000, 16'hA5C3);
    run_txn(1'b1, 24'h000002, 16'h5A3C);
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 24'h000000;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_addr = 24'h000002;
    wait_resp(lat);
    exp_rdata = ref_rd(24'h000000);
    check_eq("b2b_first_latency", 32'(lat), 32'(2 * RD_BITS));
    check_eq("b2b_first_rdata", 32'(resp_rdata), 32'(exp_rdata));
    low = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (spi_select) break;
      low++;
    end
    req_valid = 1'b0;
    check_eq("b2b_select_gap", 32'(low), 32'd2);
    wait_resp(lat);
    exp_rdata = ref_rd(24'h000002);
    check_eq("b2b_second_latency", 32'(lat), 32'(2 * RD_BITS));
    check_eq("b2b_second_rdata", 32'(resp_rdata), 32'(exp_rdata));
    check_eq("b2b_second_addr", 32'(rx_addr), 32'h000002);
    repeat (2) @(posedge clk);

    // A request pulsed while busy must be dropped.
    rc0 = resp_cnt;
    sc0 = sel_rise_cnt;
    start_req(1'b0, 24'h000010, 16'h0000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 24'h000030;
    req_wdata = 16'hDEAD;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (260) @(posedge clk);
    #1;
    exp_rdata = ref_rd(24'h000010);
    check_eq("ignore_resp_count", 32'(resp_cnt - rc0), 32'd1);
    check_eq("ignore_frame_count", 32'(sel_rise_cnt - sc0), 32'd1);
    check_eq("ignore_addr", 32'(rx_addr), 32'h000010);
    check_eq("ignore_rdata", 32'(resp_rdata), 32'(exp_rdata));
    check_eq("ignore_no_write", 32'(ram_rd(24'h000030)), 32'(ref_rd(24'h000030)));

    // Asynchronous reset in the middle of a read frame.
    rc0 = resp_cnt;
    start_req(1'b0, 24'h000020, 16'h0000);
    repeat (41) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_rdata = 16'h0000;
    check_eq("abort_spi_select", 32'(spi_select), 32'd0);
    check_eq("abort_spi_clk", 32'(spi_clk), 32'd0);
    check_eq("abort_spi_mosi", 32'(spi_mosi), 32'd0);
    check_eq("abort_req_ready", 32'(req_ready), 32'd1);
    check_eq("abort_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("abort_resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check_eq("abort_no_resp", 32'(resp_cnt - rc0), 32'd0);
    run_txn(1'b0, 24'h000010, 16'h0000);

    // Randomized mix of reads and writes over a small address window.
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      wd = 16'($urandom);
      run_txn(1'($urandom_range(0, 1)), 24'($urandom_range(0, 15)), wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
